// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// States, instruction width, PC step and default reset PC.
package ifu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DROP,
    HOLD
  } ifu_state_e;

  localparam int INST_W = 32;
  localparam int PC_STEP = 4;
  localparam logic [63:0] RESET_PC_DEF = 64'h8000_0000;

endpackage

// File: rtl/ifu_perf_cnt.sv
// Fetch-unit performance counters: accepted fetches and decode stalls.
// Instantiated by inst_fetch_unit only when IFU_PERF_CNT_EN is defined.
module ifu_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_i,
  input  logic        stall_i,
  output logic [63:0] fetch_cnt_o,
  output logic [63:0] stall_cnt_o
);

  logic [63:0] fetch_q, fetch_d;
  logic [63:0] stall_q, stall_d;

  // Increment each counter on its event; natural 64-bit wrap.
  always_comb begin
    fetch_d = fetch_q + {63'd0, fetch_i};
    stall_d = stall_q + {63'd0, stall_i};
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_q <= '0;
      stall_q <= '0;
    end else begin
      fetch_q <= fetch_d;
      stall_q <= stall_d;
    end
  end

  assign fetch_cnt_o = fetch_q;
  assign stall_cnt_o = stall_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: PC owner, single-outstanding imem read, one-entry buffer.
// Optional perf counters under `define IFU_PERF_CNT_EN.
module inst_fetch_unit
  import ifu_pkg::*;
#(
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [PC_W-1:0]   imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [INST_W-1:0] imem_resp_data,
  output logic              fetch_valid,
  output logic [INST_W-1:0] fetch_inst,
  output logic [PC_W-1:0]   fetch_pc,
  input  logic              fetch_accept,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [63:0]       perf_fetch_cnt,
  output logic [63:0]       perf_stall_cnt
`endif
);

  ifu_state_e        state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [PC_W-1:0]   fpc_q, fpc_d;

  // Next-state logic; redirect wins over every other event.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    fpc_d   = fpc_q;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = imem_req_ready ? DROP : REQ;
        end else if (imem_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = imem_resp_valid ? REQ : DROP;
        end else if (imem_resp_valid) begin
          inst_d  = imem_resp_data;
          fpc_d   = pc_q;
          state_d = HOLD;
        end
      end
      DROP: begin
        // A response here retires the stale request even if a
        // redirect also arrives, so nothing is left in flight.
        if (redirect_valid) pc_d = redirect_pc;
        if (imem_resp_valid) state_d = REQ;
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = REQ;
        end else if (fetch_accept) begin
          pc_d    = pc_q + PC_W'(PC_STEP);
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, PC and instruction buffer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      fpc_q   <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      fpc_q   <= fpc_d;
    end
  end

  assign imem_req_valid = (state_q == REQ);
  assign imem_req_addr  = pc_q;
  assign fetch_valid    = (state_q == HOLD);
  assign fetch_inst     = inst_q;
  assign fetch_pc       = fpc_q;

`ifdef IFU_PERF_CNT_EN
  logic stall;
  assign stall = (state_q == HOLD) && !fetch_accept;

  ifu_perf_cnt u_perf (
    .clk         (clk),
    .rst         (rst),
    .fetch_i     (fetch_accept),
    .stall_i     (stall),
    .fetch_cnt_o (perf_fetch_cnt),
    .stall_cnt_o (perf_stall_cnt)
  );
`endif

endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Front-end fetch stage: owns the PC, issues one instruction-memory read at a time, buffers the returned 32-bit instruction, and presents it with valid to the decode pipeline. It is the producer end of the valid/allow-in handshake that feeds the decode register stage. It also absorbs branch/jump redirects from execute, including discarding stale in-flight responses.

## Interface
- RESET_PC, 64'h8000_0000, PC loaded on reset
- PC_W, 64, PC and memory address width
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset; synchronous, active-high
- imem_req_valid  out  1  read request valid
- imem_req_ready  in  1  memory accepts request this cycle
- imem_req_addr  out  PC_W  request address (= pc)
- imem_resp_valid  in  1  read data valid; always accepted by this block
- imem_resp_data  in  32  instruction word
- fetch_valid  out  1  instruction valid toward decode (decode stage validin)
- fetch_inst  out  32  buffered instruction
- fetch_pc  out  PC_W  PC of fetch_inst
- fetch_accept  in  1  decode took the instruction this cycle (validin && decode allow-in); asserted only while fetch_valid=1
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  PC_W  restart target (4-byte aligned)

## Operation
- State machine, states IDLE, REQ, WAIT, DROP, HOLD; at most one outstanding request.
- IDLE: entered only by reset; next cycle -> REQ.
- REQ: imem_req_valid=1, imem_req_addr=pc.
  - ready && !redirect -> WAIT.
  - redirect && !ready -> pc<=redirect_pc, stay REQ (unaccepted request may change address).
  - redirect && ready -> pc<=redirect_pc, DROP (old-address request is in flight).
- WAIT: resp_valid && !redirect -> fetch_inst<=resp_data, fetch_pc<=pc, HOLD. redirect (with or without resp_valid): pc<=redirect_pc; with resp_valid, discard data -> REQ; without -> DROP.
- DROP: resp_valid -> discard -> REQ. redirect -> pc<=redirect_pc, stay DROP.
- HOLD: fetch_valid=1. accept && !redirect -> pc<=pc+4 (PC_W-bit wrap, no carry out), REQ. redirect (accept ignored) -> pc<=redirect_pc, buffer invalidated, REQ. Neither -> hold fetch_inst/fetch_pc stable.
- imem_resp_valid in IDLE/REQ/HOLD is a protocol violation; ignored, no state change.
- redirect always has priority over every other event in the same cycle.

## Timing
- Reset values: state IDLE, pc RESET_PC, imem_req_valid 0, imem_req_addr RESET_PC, fetch_valid 0, fetch_inst 0, fetch_pc RESET_PC.
- imem_req_valid, imem_req_addr, fetch_valid, fetch_inst, fetch_pc are direct register/state decodes; no combinational path from any input.
- Zero-wait memory (ready in REQ cycle, resp next cycle): rst low at cycle 0 -> REQ cycle 1 -> WAIT cycle 2 -> fetch_valid cycle 3. Steady state with fetch_accept in HOLD: 1 instruction per 3 cycles.
- fetch_valid drops the cycle after accept or redirect.
- rst mid-operation (any state) returns to reset values next edge; memory shares rst, so no stale response survives.

## Configuration
- IFU_PERF_CNT_EN defined: adds outputs perf_fetch_cnt (64) counting fetch_accept cycles, and perf_stall_cnt (64) counting HOLD cycles without accept; both reset to 0, wrap at 2^64, do not count during rst.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- Package ifu_pkg: state enum (IDLE, REQ, WAIT, DROP, HOLD), INST_W=32, PC_STEP=4, default RESET_PC.
- One sub-module: ifu_perf_cnt (the two counters), instantiated only under IFU_PERF_CNT_EN.

## Test plan
- Reset release, memory ready always, resp 1 cycle later with data 32'h0000_0013 -> imem_req_addr 8000_0000 cycle 1, fetch_valid=1 with fetch_pc 8000_0000, fetch_inst 0000_0013 cycle 3.
- fetch_accept held low 5 cycles in HOLD -> fetch_valid, fetch_inst, fetch_pc stable; no new request; then accept -> next request addr 8000_0004.
- Redirect to 8000_0100 in WAIT, resp arriving 2 cycles later -> DROP, data discarded, next request 8000_0100, fetch_valid never shows stale word.
- Redirect and resp_valid same cycle in WAIT -> data discarded, REQ with 8000_0100 next cycle.
- imem_req_ready low 3 cycles with redirect on cycle 2 -> address switches to redirect_pc; accepted request uses new address; no DROP.
- pc=FFFF_FFFF_FFFF_FFFC accepted -> next request address 0; with IFU_PERF_CNT_EN, perf_fetch_cnt increments by exactly 1 per accept.
